// File: rtl/dds_spi_cfg_bridge.sv
// SPI-mode-0 slave to DDS parallel register port bridge; one write or sync pulse per frame.
// Define DDS_CFG_PARITY_EN for 34-bit frames carrying a trailing even-parity bit.
module dds_spi_cfg_bridge #(
    parameter logic [8:0]  SYNC_ADDR = 9'h1FE,
    parameter int unsigned SYNC_LEN  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic [8:0]  addr,
    output logic [23:0] data,
    output logic        wr_en,
    output logic        sync,
    output logic        busy,
    output logic [7:0]  err_cnt
);

`ifdef DDS_CFG_PARITY_EN
    localparam int FRAME_LEN = 34;
`else
    localparam int FRAME_LEN = 33;
`endif
    localparam logic [5:0] FRAME_LEN_C = 6'(FRAME_LEN);
    localparam logic [3:0] SYNC_LEN_C  = 4'(SYNC_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_WRITE, ST_SYNC} state_t;

    // Per pin: [0] and [1] form the synchroniser, [2] is the history flop.
    logic [2:0] sclk_q, csn_q, mosi_q;
    logic       sclk_rise, csn_fall, csn_rise;

    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_q <= 3'b000;
            csn_q  <= 3'b111;
            mosi_q <= 3'b000;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            csn_q  <= {csn_q[1:0], spi_csn};
            mosi_q <= {mosi_q[1:0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign csn_fall  = ~csn_q[1] & csn_q[2];
    assign csn_rise  = csn_q[1] & ~csn_q[2];

    // Only the last FRAME_LEN bits shifted in can ever form a valid frame.
    logic [FRAME_LEN-1:0] shift_q;
    logic [5:0]           bit_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (csn_fall) begin
            bit_cnt_q <= '0;
        end else if (!csn_q[1] && sclk_rise) begin
            // mosi history sample was taken before the sclk rise reached the pins' sync chain.
            shift_q <= {shift_q[FRAME_LEN-2:0], mosi_q[2]};
            if (bit_cnt_q != 6'd63) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
            end
        end
    end

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic [5:0]           len_q, len_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [8:0]           addr_q, addr_d;
    logic [23:0]          data_q, data_d;
    logic [7:0]           err_q, err_d;
    logic                 wr_en_q, sync_q, busy_q;
    logic [1:0]           err_inc;
    logic [8:0]           err_sum;
    logic                 frame_valid;
    logic [8:0]           frame_addr;
    logic [23:0]          frame_data;

    assign frame_addr = frame_q[FRAME_LEN-1 -: 9];
    assign frame_data = frame_q[FRAME_LEN-10 -: 24];
`ifdef DDS_CFG_PARITY_EN
    assign frame_valid = (len_q == FRAME_LEN_C) && !(^frame_q);
`else
    assign frame_valid = (len_q == FRAME_LEN_C);
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_inc = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (csn_rise) begin
                    frame_d = shift_q;
                    len_d   = bit_cnt_q;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!frame_valid) begin
                    err_inc = 2'd1;
                    state_d = ST_IDLE;
                end else if (frame_addr == SYNC_ADDR) begin
                    cnt_d   = SYNC_LEN_C;
                    state_d = ST_SYNC;
                end else begin
                    addr_d  = frame_addr;
                    data_d  = frame_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_SYNC: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A frame ending while the previous one is still being handled is dropped.
        if (csn_rise && state_q != ST_IDLE) begin
            err_inc = err_inc + 2'd1;
        end
        err_sum = 9'(err_q) + 9'(err_inc);
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= '0;
            wr_en_q <= 1'b0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wr_en_q <= (state_d == ST_WRITE);
            sync_q  <= (state_d == ST_SYNC);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign addr    = addr_q;
    assign data    = data_q;
    assign wr_en   = wr_en_q;
    assign sync    = sync_q;
    assign busy    = busy_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_dds_spi_cfg_bridge.sv
// Randomised scoreboard bench for dds_spi_cfg_bridge: frames are predicted when sent and
// a monitor matches every wr_en, sync pulse and err_cnt step against the expected queue.
module tb_dds_spi_cfg_bridge;

    localparam logic [8:0] SYNC_ADDR = 9'h1FE;
    localparam int         SYNC_LEN  = 4;
`ifdef DDS_CFG_PARITY_EN
    localparam int FLEN = 34;
`else
    localparam int FLEN = 33;
`endif
    localparam int EV_WRITE = 0;
    localparam int EV_SYNC  = 1;
    localparam int EV_ERR   = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [8:0]  addr;
    logic [23:0] data;
    logic        wr_en, sync, busy;
    logic [7:0]  err_cnt;

    dds_spi_cfg_bridge #(.SYNC_ADDR(SYNC_ADDR), .SYNC_LEN(SYNC_LEN)) dut (
        .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_csn(spi_csn),
        .spi_mosi(spi_mosi), .addr(addr), .data(data), .wr_en(wr_en),
        .sync(sync), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [8:0]  a;
        logic [23:0] d;
        int          err;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          m_err = 0;
    logic [8:0]  m_addr = '0;
    logic [23:0] m_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] mk_frame(input logic [8:0] a, input logic [23:0] d);
        logic [32:0] p;
        p = {a, d};
`ifdef DDS_CFG_PARITY_EN
        return {30'b0, p, ^p};
`else
        return {31'b0, p};
`endif
    endfunction

    // Reference: a frame is accepted only at exactly FLEN bits (and even parity when enabled).
    task automatic predict(input logic [63:0] v, input int n);
        ev_t         e;
        logic [8:0]  a;
        logic [23:0] d;
        bit          ok;
        ok = (n == FLEN);
`ifdef DDS_CFG_PARITY_EN
        if (^v[33:0]) ok = 1'b0;
`endif
        a = v[FLEN-1 -: 9];
        d = v[FLEN-10 -: 24];
        if (ok) begin
            if (a != SYNC_ADDR) begin
                m_addr = a;
                m_data = d;
            end
            e.kind = (a == SYNC_ADDR) ? EV_SYNC : EV_WRITE;
            e.a = m_addr; e.d = m_data; e.err = m_err;
            exp_q.push_back(e);
        end else if (m_err < 255) begin
            m_err++;
            e.kind = EV_ERR; e.a = m_addr; e.d = m_data; e.err = m_err;
            exp_q.push_back(e);
        end
    endtask

    // sclk at clk/8; mosi changes with the falling sclk edge, MSB first.
    task automatic spi_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = (i < 64) ? v[i] : 1'b0;
            wait_clk(4);
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [63:0] v, input int n);
        predict(v, n);
        spi_csn = 1'b0;
        wait_clk(4);
        spi_bits(v, n);
        wait_clk(4);
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(20);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_sync"}, 64'(sync), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    endtask

    // Monitor: every DUT event must match the head of the expectation queue.
    logic [7:0] prev_err = '0;
    logic       prev_sync = 1'b0;
    int         sync_run = 0;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_err  = '0;
            prev_sync = 1'b0;
            sync_run  = 0;
        end else begin
            if (wr_en) begin
                check("wr_en_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_kind", 64'(EV_WRITE), 64'(mon_e.kind));
                    check("wr_addr", 64'(addr), 64'(mon_e.a));
                    check("wr_data", 64'(data), 64'(mon_e.d));
                    check("wr_err_cnt", 64'(err_cnt), 64'(mon_e.err));
                    check("wr_busy", 64'(busy), 64'd1);
                end
            end
            if (sync && !prev_sync) begin
                check("sync_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sync_kind", 64'(EV_SYNC), 64'(mon_e.kind));
                    check("sync_addr_held", 64'(addr), 64'(mon_e.a));
                    check("sync_data_held", 64'(data), 64'(mon_e.d));
                end
            end
            if (sync) sync_run++;
            else if (prev_sync) begin
                check("sync_len", 64'(sync_run), 64'(SYNC_LEN));
                sync_run = 0;
            end
            if (err_cnt != prev_err) begin
                check("err_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("err_kind", 64'(EV_ERR), 64'(mon_e.kind));
                    check("err_value", 64'(err_cnt), 64'(mon_e.err));
                end
            end
            prev_err  = err_cnt;
            prev_sync = sync;
        end
    end

    logic [63:0] fv;
    logic [8:0]  ra;
    logic [23:0] rd;
    int          r;

    initial begin
        wait_clk(3);
        check_all_zero("reset");
        resetn = 1'b1;
        wait_clk(5);

        spi_frame(mk_frame(9'h003, 24'h001A37), FLEN);
        check("first_err_cnt", 64'(err_cnt), 64'd0);
        spi_frame(mk_frame(SYNC_ADDR, 24'($urandom)), FLEN);

        spi_frame({$urandom, $urandom}, 32);
        spi_frame({$urandom, $urandom}, 40);
        spi_frame(64'd0, 0);
        check("err_after_three_bad", 64'(err_cnt), 64'd3);

        fv = mk_frame(9'h055, 24'h123456);
        spi_frame((fv << 1) | 64'd1, FLEN + 1);
        spi_frame(fv, FLEN + 64);   // bit count saturates rather than wrapping to FLEN
        spi_frame(fv, FLEN - 1);
        spi_frame(fv, FLEN);

        for (int k = 0; k < 30; k++) begin
            r  = int'($urandom_range(0, 9));
            ra = 9'($urandom);
            rd = 24'($urandom);
            if (r < 6) spi_frame(mk_frame((ra == SYNC_ADDR) ? 9'h010 : ra, rd), FLEN);
            else if (r < 7) spi_frame(mk_frame(SYNC_ADDR, rd), FLEN);
            else spi_frame({$urandom, $urandom}, int'($urandom_range(0, 40)));
        end

        for (int k = 0; k < 260; k++) spi_frame(64'd0, 0);
        check("err_saturated", 64'(err_cnt), 64'd255);
        check("queue_empty_before_reset", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a frame: the partial frame vanishes without an error.
        spi_csn = 1'b0;
        wait_clk(4);
        spi_bits({$urandom, $urandom}, 20);
        resetn = 1'b0;
        wait_clk(2);
        check_all_zero("mid_frame_reset");
        spi_csn  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        wait_clk(3);
        m_err  = 0;
        m_addr = '0;
        m_data = '0;
        exp_q.delete();
        resetn = 1'b1;
        wait_clk(5);
        spi_frame(mk_frame(9'h1FF, 24'h000081), FLEN);
        check("post_reset_err_cnt", 64'(err_cnt), 64'd0);
        check("post_reset_data", 64'(data), 64'h000081);

`ifdef DDS_CFG_PARITY_EN
        fv = mk_frame(9'h0A5, 24'hC0FFEE);
        spi_frame(fv, FLEN);
        spi_frame(fv ^ 64'd1, FLEN);
        check("parity_err_cnt", 64'(err_cnt), 64'd1);
`endif

        wait_clk(40);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_err_cnt", 64'(err_cnt), 64'(m_err));
        check("final_busy", 64'(busy), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
